hdlc_stream_tx: RTL and testbench

HDLC frame transmitter for the RS422 link: accepts payload bytes on an 8-bit AXI-Stream slave (one frame per `tlast`-terminated packet) and drives a divided bit clock plus a serial bit stream carrying opening flag, bit-stuffed payload, CRC-16 FCS and closing flag. It is the transmit-side counterpart of the existing HDLC stream receiver: `tx_clk`/`tx_data` connect to the RS422 transmit pins, and its output is a valid input to that receiver.

---
 rtl/hdlc_pkg.sv | 15 +
 rtl/hdlc_crc16.sv | 23 ++
 rtl/hdlc_stream_tx.sv | 171 +++++++++++++++++
 tb/tb_hdlc_stream_tx.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlc_pkg.sv
// rtl/hdlc_pkg.sv - shared HDLC framing constants and transmit state type
package hdlc_pkg;
  localparam logic [7:0]  HDLC_FLAG    = 8'h7E;
  localparam logic [15:0] CRC16_POLY_R = 16'h8408;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPEN,
    ST_DATA,
    ST_FCS,
    ST_CLOSE,
    ST_ABORT
  } hdlc_tx_state_t;
endpackage

// File: rtl/hdlc_crc16.sv
// rtl/hdlc_crc16.sv - bit-serial reflected CRC-16/X.25 accumulator
module hdlc_crc16
  import hdlc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic        data,
  output logic [15:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC16_INIT;
    end else if (clear) begin
      crc <= CRC16_INIT;
    end else if (enable) begin
      crc <= (crc >> 1) ^ ((crc[0] ^ data) ? CRC16_POLY_R : 16'h0000);
    end
  end

endmodule

// File: rtl/hdlc_stream_tx.sv
// rtl/hdlc_stream_tx.sv - HDLC frame transmitter: byte stream in, flag/stuffed payload/FCS out
module hdlc_stream_tx
  import hdlc_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tlast,
  input  logic [7:0] s_tdata,
  output logic       tx_clk,
  output logic       tx_data,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  hdlc_tx_state_t state;
  logic [DW-1:0]  div_cnt;
  logic [4:0]     idx;
  logic [2:0]     stuff_cnt;
  logic [7:0]     sh;
  logic           sh_last;
  logic [7:0]     hold_data;
  logic           hold_last;
  logic           hold_full;
  logic           ready_en;
  logic [15:0]    crc;

  logic       tick;
  logic       idle_entry;
  logic       stuff_now;
  logic       line_bit;
  logic [2:0] stuff_nxt;
  logic       crc_clear;
  logic       crc_en;

  assign tick       = (div_cnt == DIV_LAST);
  assign tx_clk     = (div_cnt >= DIV_HALF);
  assign busy       = (state != ST_IDLE);
  assign s_tready   = ready_en && !hold_full && (state != ST_ABORT);
  assign stuff_now  = (stuff_cnt == 3'd5);
  assign line_bit   = (state == ST_FCS) ? ~crc[idx[3:0]] : sh[idx[2:0]];
  assign stuff_nxt  = line_bit ? stuff_cnt + 3'd1 : 3'd0;
  // CLOSE and ABORT finish one tick after their last bit so the line can go straight into the next OPEN
  assign idle_entry = tick && ((state == ST_IDLE) ||
                               (state == ST_CLOSE && idx == 5'd8) ||
                               (state == ST_ABORT && idx == 5'd7));
  assign crc_clear  = idle_entry && hold_full;
  assign crc_en     = tick && (state == ST_DATA) && !stuff_now;

  hdlc_crc16 u_crc (
    .clk    (clk),
    .rst    (rst),
    .clear  (crc_clear),
    .enable (crc_en),
    .data   (line_bit),
    .crc    (crc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      div_cnt    <= '0;
      idx        <= '0;
      stuff_cnt  <= '0;
      sh         <= '0;
      sh_last    <= 1'b0;
      hold_data  <= '0;
      hold_last  <= 1'b0;
      hold_full  <= 1'b0;
      ready_en   <= 1'b0;
      tx_data    <= 1'b1;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      ready_en   <= 1'b1;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      div_cnt    <= tick ? '0 : div_cnt + DW'(1);

      if (s_tvalid && s_tready) begin
        hold_data <= s_tdata;
        hold_last <= s_tlast;
        hold_full <= 1'b1;
      end

      if (idle_entry) begin
        frame_done <= (state == ST_CLOSE);
        if (hold_full) begin
          state     <= ST_OPEN;
          tx_data   <= HDLC_FLAG[0];
          idx       <= 5'd1;
          stuff_cnt <= '0;
        end else begin
          state   <= ST_IDLE;
          tx_data <= 1'b1;
          idx     <= '0;
        end
      end else if (tick) begin
        unique case (state)
          ST_OPEN: begin
            tx_data <= HDLC_FLAG[idx[2:0]];
            if (idx == 5'd7) begin
              state     <= ST_DATA;
              idx       <= '0;
              sh        <= hold_data;
              sh_last   <= hold_last;
              hold_full <= 1'b0;
            end else begin
              idx <= idx + 5'd1;
            end
          end
          ST_DATA, ST_FCS: begin
            if (stuff_now) begin
              tx_data   <= 1'b0;
              stuff_cnt <= '0;
              if (state == ST_FCS && idx == 5'd16) begin
                state <= ST_CLOSE;
                idx   <= '0;
              end
            end else begin
              tx_data   <= line_bit;
              stuff_cnt <= stuff_nxt;
              if (state == ST_DATA && idx == 5'd7) begin
                idx <= '0;
                if (sh_last) begin
                  state <= ST_FCS;
                end else if (hold_full) begin
                  sh        <= hold_data;
                  sh_last   <= hold_last;
                  hold_full <= 1'b0;
                end else begin
                  state    <= ST_ABORT;
                  underrun <= 1'b1;
                end
              end else if (state == ST_FCS && idx == 5'd15) begin
                // a trailing run of five 1s still owes its stuffed 0 before the closing flag
                if (stuff_nxt == 3'd5) begin
                  idx <= 5'd16;
                end else begin
                  state     <= ST_CLOSE;
                  idx       <= '0;
                  stuff_cnt <= '0;
                end
              end else begin
                idx <= idx + 5'd1;
              end
            end
          end
          ST_CLOSE: begin
            tx_data <= HDLC_FLAG[idx[2:0]];
            idx     <= idx + 5'd1;
          end
          ST_ABORT: begin
            tx_data <= 1'b1;
            idx     <= idx + 5'd1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hdlc_stream_tx.sv
// tb/tb_hdlc_stream_tx.sv - randomized bench with a frame-level line model for hdlc_stream_tx
module tb_hdlc_stream_tx;

  localparam int CLK_DIV = 4;

  typedef logic [7:0] byteq_t[$];
  typedef bit bitq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic       s_tvalid;
  logic       s_tready;
  logic       s_tlast;
  logic [7:0] s_tdata;
  logic       tx_clk;
  logic       tx_data;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  hdlc_stream_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tlast    (s_tlast),
    .s_tdata    (s_tdata),
    .tx_clk     (tx_clk),
    .tx_data    (tx_data),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  bit exp_q[$];
  int end_q[$];
  bit in_frame = 0;
  int bits_in_frame = 0;
  int last_frame_bits = 0;
  int last_len = 0;
  int idle_run = 0;
  int last_gap = -1;
  int pending_done = 0;
  int pending_underrun = 0;
  int done_count = 0;
  int underrun_count = 0;
  bit prev_tx_clk = 0;
  bit prev_busy = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int done_cyc = 0;
  bit cmp_bit;
  int cmp_end;

  task automatic check_eq(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic [15:0] model_fcs(input byteq_t b);
    logic [15:0] c = 16'hFFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        if (c[0] ^ b[i][k]) c = (c >> 1) ^ 16'h8408;
        else c = c >> 1;
      end
    end
    return ~c;
  endfunction

  function automatic bitq_t stuff(input bitq_t raw, input bit drop_tail);
    bitq_t q;
    int ones = 0;
    foreach (raw[i]) begin
      q.push_back(raw[i]);
      ones = raw[i] ? ones + 1 : 0;
      if (ones == 5 && !(drop_tail && i == raw.size() - 1)) begin
        q.push_back(1'b0);
        ones = 0;
      end
    end
    return q;
  endfunction

  // Expected line bits for one frame; an aborted frame is the flag, the stuffed partial payload and seven 1s
  task automatic push_frame(input byteq_t b, input bit abort);
    bitq_t raw, st;
    logic [15:0] f;
    logic [7:0] flag = 8'h7E;
    foreach (b[i]) for (int k = 0; k < 8; k++) raw.push_back(b[i][k]);
    if (!abort) begin
      f = model_fcs(b);
      for (int k = 0; k < 16; k++) raw.push_back(f[k]);
    end
    st = stuff(raw, abort);
    for (int k = 0; k < 8; k++) begin exp_q.push_back(flag[k]); end_q.push_back(0); end
    foreach (st[i]) begin exp_q.push_back(st[i]); end_q.push_back(0); end
    for (int k = 0; k < (abort ? 7 : 8); k++) begin
      exp_q.push_back(abort ? 1'b1 : flag[k]);
      end_q.push_back(0);
    end
    end_q[end_q.size() - 1] = abort ? 2 : 1;
    last_len = 8 + st.size() + (abort ? 7 : 8);
    if (abort) pending_underrun++;
  endtask

  task automatic send_frame(input byteq_t b, input bit last, input int gap_max);
    int g;
    int n;
    foreach (b[i]) begin
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      repeat (g) begin @(negedge clk); s_tvalid = 1'b0; end
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = b[i];
      s_tlast  = last && (i == b.size() - 1);
      n = 0;
      while (!s_tready && n < 4000) begin @(negedge clk); n++; end
      check_eq("accept_in_time", int'(n < 4000), 1);
      @(posedge clk);
    end
  endtask

  task automatic idle_bus();
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || in_frame || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq(name, int'(n < 5000), 1);
    repeat (2) @(negedge clk);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (busy && !prev_busy) rise_cyc = cyc;
    if (frame_done) done_cyc = cyc;
    prev_busy = busy;
  end

  // Line checker: samples on rising tx_clk, as the receiver does
  always @(negedge clk) begin
    if (rst) begin
      prev_tx_clk = 1'b0;
    end else begin
      if (tx_clk && !prev_tx_clk) begin
        if (!in_frame) begin
          if (tx_data == 1'b0) begin
            check_eq("frame_start_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
              in_frame = 1;
              last_gap = idle_run;
              bits_in_frame = 0;
            end
          end else begin
            idle_run++;
          end
        end
        if (in_frame) begin
          cmp_bit = exp_q.pop_front();
          cmp_end = end_q.pop_front();
          check_eq("line_bit", int'(tx_data), int'(cmp_bit));
          check_eq("busy_in_frame", int'(busy), 1);
          bits_in_frame++;
          if (cmp_end != 0) begin
            in_frame = 0;
            idle_run = 0;
            last_frame_bits = bits_in_frame;
            if (cmp_end == 1) pending_done++;
          end
        end
      end
      if (frame_done) begin
        done_count++;
        check_eq("frame_done_expected", int'(pending_done > 0), 1);
        if (pending_done > 0) pending_done--;
      end
      if (underrun) begin
        underrun_count++;
        check_eq("underrun_expected", int'(pending_underrun > 0), 1);
        if (pending_underrun > 0) pending_underrun--;
      end
      prev_tx_clk = tx_clk;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    byteq_t fr, fr2, ff;
    bitq_t sq, ones8;
    logic [15:0] f;
    int v, d0, u0, n;

    rst = 1'b1;
    s_tvalid = 1'b1;
    s_tlast = 1'b1;
    s_tdata = 8'hA5;
    repeat (3) @(negedge clk);
    check_eq("rst_tx_data", int'(tx_data), 1);
    check_eq("rst_tx_clk", int'(tx_clk), 0);
    check_eq("rst_s_tready", int'(s_tready), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_frame_done", int'(frame_done), 0);
    check_eq("rst_underrun", int'(underrun), 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("tready_after_release", int'(s_tready), 1);
    s_tvalid = 1'b0;

    for (int i = 0; i < 9; i++) fr.push_back(8'(8'h31 + i));
    f = model_fcs(fr);
    check_eq("model_fcs_lo", int'(f[7:0]), 'h6E);
    check_eq("model_fcs_hi", int'(f[15:8]), 'h90);
    for (int i = 0; i < 8; i++) ones8.push_back(1'b1);
    sq = stuff(ones8, 1'b0);
    check_eq("model_stuff_len", sq.size(), 9);
    v = 0;
    for (int i = 0; i < 9; i++) v = v | (int'(sq[i]) << i);
    check_eq("model_stuff_bits", v, 'h1DF);

    // "123456789"
    push_frame(fr, 1'b0);
    send_frame(fr, 1'b1, 0);
    idle_bus();
    wait_idle("frame_123_done");
    check_eq("frame_123_done_count", done_count, 1);
    check_eq("frame_123_bits", last_frame_bits, last_len);
    check_eq("frame_123_duration", done_cyc - rise_cyc, last_len * CLK_DIV);
    check_eq("idle_tx_data", int'(tx_data), 1);

    // single 0xFF
    ff.delete();
    ff.push_back(8'hFF);
    push_frame(ff, 1'b0);
    send_frame(ff, 1'b1, 0);
    idle_bus();
    wait_idle("frame_ff_done");
    check_eq("frame_ff_bits", last_frame_bits, last_len);

    // back-to-back 3-byte frames
    d0 = done_count;
    fr.delete();
    fr2.delete();
    for (int i = 0; i < 3; i++) begin
      fr.push_back(8'($urandom));
      fr2.push_back(8'($urandom));
    end
    push_frame(fr, 1'b0);
    push_frame(fr2, 1'b0);
    send_frame(fr, 1'b1, 0);
    send_frame(fr2, 1'b1, 0);
    idle_bus();
    wait_idle("b2b_done");
    check_eq("b2b_done_pulses", done_count - d0, 2);
    check_eq("b2b_gap_bits", last_gap, 0);

    // underrun
    u0 = underrun_count;
    fr.delete();
    fr.push_back(8'h01);
    push_frame(fr, 1'b1);
    send_frame(fr, 1'b0, 0);
    idle_bus();
    wait_idle("abort_done");
    check_eq("abort_underrun_pulses", underrun_count - u0, 1);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_tx_data", int'(tx_data), 1);
    check_eq("abort_tready", int'(s_tready), 1);

    // reset during FCS
    fr.delete();
    fr.push_back(8'($urandom));
    push_frame(fr, 1'b0);
    send_frame(fr, 1'b1, 0);
    idle_bus();
    n = 0;
    while (!(in_frame && bits_in_frame >= 20) && n < 2000) begin @(negedge clk); n++; end
    check_eq("reached_fcs", int'(n < 2000), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_tx_data", int'(tx_data), 1);
    check_eq("midrst_tx_clk", int'(tx_clk), 0);
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_s_tready", int'(s_tready), 0);
    check_eq("midrst_frame_done", int'(frame_done), 0);
    exp_q.delete();
    end_q.delete();
    in_frame = 0;
    pending_done = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fr.delete();
    for (int i = 0; i < 2; i++) fr.push_back(8'($urandom));
    push_frame(fr, 1'b0);
    send_frame(fr, 1'b1, 0);
    idle_bus();
    wait_idle("post_reset_frame");
    check_eq("post_reset_bits", last_frame_bits, last_len);

    // randomized frames with input gaps and 0xFF-heavy payloads
    for (int k = 0; k < 12; k++) begin
      fr.delete();
      for (int i = 0; i < int'($urandom_range(1, 8)); i++)
        fr.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      push_frame(fr, 1'b0);
      send_frame(fr, 1'b1, 6);
    end
    idle_bus();
    wait_idle("random_done");

    check_eq("final_queue_empty", exp_q.size(), 0);
    check_eq("final_pending_done", pending_done, 0);
    check_eq("final_pending_underrun", pending_underrun, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
